// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, parity modes and the baud
// accumulator increment helper (also meant for a future receiver).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Rounded fractional increment: tick rate = clk_freq * inc / 2**acc_width.
    function automatic int unsigned baud_inc(input longint unsigned clk_freq,
                                             input longint unsigned baud,
                                             input int unsigned     acc_width);
        longint unsigned num;
        num = (baud << (acc_width - 4)) + (clk_freq >> 5);
        return 32'(num / (clk_freq >> 4));
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional-accumulator baud tick generator; the accumulator is cleared
// whenever en is low so each frame starts from a known phase.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned ACC_W = ACC_WIDTH + 1;
    localparam int unsigned INC   = baud_inc(CLK_FREQ, BAUD, ACC_WIDTH);

    logic [ACC_WIDTH:0] r_acc;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_acc <= '0;
        end else begin
            r_acc <= {1'b0, r_acc[ACC_WIDTH-1:0]} + ACC_W'(INC);
        end
    end

    assign tick = r_acc[ACC_WIDTH];

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and back-to-back framing.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned ACC_WIDTH  = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 4;

    if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        PARITY > PAR_ODD) begin : g_bad_cfg
        $error("uart_tx_fifo: illegal parameter set");
    end

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;

    tx_state_e            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic                 r_tx;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_tick;
    logic                 w_en;
    logic                 w_frame_end;
    logic [DATA_BITS-1:0] w_rd_data;

    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty     = (r_level == '0);
    assign w_wr        = s_valid && !w_full;
    assign w_rd_data   = r_mem[r_rd_ptr];
    assign w_frame_end = (r_state == STOP) && w_tick &&
                         (r_bit_cnt == CNT_W'(STOP_BITS - 1));
    assign w_pop       = !w_empty && ((r_state == IDLE) || w_frame_end);
    // Accumulator runs from the pop cycle so the first bit is a full bit long.
    assign w_en        = w_pop || ((r_state != IDLE) && !w_frame_end);

    uart_baud_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_baud_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);

    logic r_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_pop) begin
            r_par <= (PARITY == PAR_ODD) ? ~^w_rd_data : ^w_rd_data;
        end
    end
`endif

    // Frame sequencer; tx follows the state one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            r_state   <= PAR_ON ? uart_pkg::PARITY : STOP;
`else
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                uart_pkg::PARITY: begin
                    if (w_tick) begin
                        r_state   <= STOP;
                        r_bit_cnt <= '0;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        if (w_frame_end) begin
                            r_bit_cnt <= '0;
                            r_state   <= w_pop ? START : IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_pop) begin
                r_shift   <= w_rd_data;
                r_bit_cnt <= '0;
            end

            case (r_state)
                START:            r_tx <= 1'b0;
                DATA:             r_tx <= r_shift[0];
`ifdef UART_TX_PARITY_EN
                uart_pkg::PARITY: r_tx <= r_par;
`endif
                default:          r_tx <= 1'b1;
            endcase
        end
    end

    assign s_ready    = !w_full;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE) || (r_level != '0);
    assign fifo_level = r_level;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: three configurations share one clock,
// a line monitor decodes frames and compares them against a scoreboard queue.
module tb_uart_tx_fifo;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 100000;
    localparam int          BIT_CYC  = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON_B = 1'b1;
`else
    localparam bit PAR_ON_B = 1'b0;
`endif

    typedef struct {
        logic [15:0] bits;
        int          len;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] drv_data = '0;
    logic       drv_valid = 1'b0;
    int         sel = 0;

    logic       valid_a, valid_b, valid_c;
    logic       ready_a, ready_b, ready_c;
    logic       tx_a, tx_b, tx_c;
    logic       busy_a, busy_b, busy_c;
    logic [2:0] level_a, level_b, level_c;
    logic       tx_mon, busy_mon, ready_mon;
    logic [2:0] level_mon;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    frame_t     sb[$];
    int         fall_q[$];
    logic [8:0] wq[$];
    int         cfg_dbits = 8;
    int         cfg_stop = 1;
    bit         cfg_par = 1'b0;
    bit         cfg_odd = 1'b0;
    int         peak = 0;
    int         full_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign valid_a = drv_valid && (sel == 0);
    assign valid_b = drv_valid && (sel == 1);
    assign valid_c = drv_valid && (sel == 2);

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ACC_WIDTH(16), .DATA_BITS(8),
                   .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) u_dut_a (
        .clk(clk), .rst(rst), .s_data(drv_data[7:0]), .s_valid(valid_a),
        .s_ready(ready_a), .tx(tx_a), .busy(busy_a), .fifo_level(level_a));

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ACC_WIDTH(16), .DATA_BITS(7),
                   .STOP_BITS(2), .PARITY(2), .FIFO_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .s_data(drv_data[6:0]), .s_valid(valid_b),
        .s_ready(ready_b), .tx(tx_b), .busy(busy_b), .fifo_level(level_b));

    uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ACC_WIDTH(16), .DATA_BITS(9),
                   .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4)) u_dut_c (
        .clk(clk), .rst(rst), .s_data(drv_data), .s_valid(valid_c),
        .s_ready(ready_c), .tx(tx_c), .busy(busy_c), .fifo_level(level_c));

    always_comb begin
        case (sel)
            1: begin tx_mon = tx_b; busy_mon = busy_b; ready_mon = ready_b; level_mon = level_b; end
            2: begin tx_mon = tx_c; busy_mon = busy_c; ready_mon = ready_c; level_mon = level_c; end
            default: begin tx_mon = tx_a; busy_mon = busy_a; ready_mon = ready_a; level_mon = level_a; end
        endcase
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line image, LSB = start bit; unused upper bits stay 1.
    function automatic frame_t make_frame(input logic [8:0] d);
        frame_t f;
        int     n;
        logic   p;
        f.bits = '1;
        p = 1'b0;
        f.bits[0] = 1'b0;
        n = 1;
        for (int i = 0; i < cfg_dbits; i++) begin
            f.bits[n] = d[i];
            p = p ^ d[i];
            n++;
        end
        if (cfg_par) begin
            f.bits[n] = cfg_odd ? ~p : p;
            n++;
        end
        f.len = n + cfg_stop;
        return f;
    endfunction

    task automatic track();
        if (int'(level_mon) > peak) peak = int'(level_mon);
        if (level_mon == 3'd4 && ready_mon !== 1'b0) full_bad++;
    endtask

    // Holds s_valid and advances the word each time the DUT accepts.
    task automatic send_seq();
        int   i;
        int   guard;
        logic acc;
        i = 0;
        guard = 0;
        drv_data = wq[0];
        drv_valid = 1'b1;
        while (i < wq.size() && guard < 2000) begin
            acc = ready_mon;
            @(negedge clk);
            guard++;
            track();
            if (acc) begin
                sb.push_back(make_frame(wq[i]));
                i++;
                if (i < wq.size()) drv_data = wq[i];
            end
        end
        drv_valid = 1'b0;
        check_eq("send_accept_count", 32'(i), 32'(wq.size()));
    endtask

    task automatic wait_idle(input int budget, output int t);
        int n;
        n = 0;
        while (busy_mon === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
            track();
        end
        t = cyc;
        check_eq("idle_within_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic set_cfg(input int s);
        sel       = s;
        cfg_dbits = (s == 1) ? 7 : (s == 2) ? 9 : 8;
        cfg_stop  = (s == 1) ? 2 : 1;
        cfg_par   = (s == 1) && PAR_ON_B;
        cfg_odd   = (s == 1);
        fall_q.delete();
        peak      = 0;
        full_bad  = 0;
    endtask

    // Line monitor: mid-bit sampling, abandons a frame cut by reset.
    initial begin : monitor
        logic        prev;
        logic [15:0] got;
        frame_t      exp;
        bit          abort;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev === 1'b1 && tx_mon === 1'b0) begin
                fall_q.push_back(cyc);
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_frame observed=start_bit expected=no_frame");
                end
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                end else begin
                    exp.bits = '1;
                    exp.len  = 10;
                end
                got = '1;
                abort = 1'b0;
                for (int k = 0; k < exp.len && !abort; k++) begin
                    repeat ((k == 0) ? BIT_CYC / 2 : BIT_CYC) begin
                        @(negedge clk);
                        if (rst) abort = 1'b1;
                    end
                    if (!abort) got[k] = tx_mon;
                end
                if (!abort) check_eq("frame_bits", 32'(got), 32'(exp.bits));
            end
            prev = tx_mon;
        end
    end

    initial begin : main
        int t_idle;
        int f0;
        int n;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx_a), 32'd1);
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_ready", 32'(ready_a), 32'd1);
        check_eq("rst_level", 32'(level_a), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 8N1 frame
        set_cfg(0);
        wq.delete(); wq.push_back(9'h0A5);
        send_seq();
        wait_idle(400, t_idle);
        check_eq("t1_frames_seen", 32'(fall_q.size()), 32'd1);
        f0 = (fall_q.size() > 0) ? fall_q[0] : 0;
        check_eq("t1_busy_fall_offset", 32'(t_idle - f0), 32'(BIT_CYC * 10 - 1));
        repeat (20) @(negedge clk);

        // Back-to-back frames
        set_cfg(0);
        wq.delete(); wq.push_back(9'h000); wq.push_back(9'h0FF); wq.push_back(9'h055);
        send_seq();
        wait_idle(800, t_idle);
        check_eq("t2_peak_level", 32'(peak), 32'd2);
        check_eq("t2_frames_seen", 32'(fall_q.size()), 32'd3);
        for (int i = 1; i < fall_q.size(); i++)
            check_eq("t2_frame_spacing", 32'(fall_q[i] - fall_q[i-1]), 32'(BIT_CYC * 10));
        repeat (20) @(negedge clk);

        // Full FIFO back-pressure
        set_cfg(0);
        wq.delete();
        for (int i = 1; i <= 6; i++) wq.push_back(9'(i * 9'h011));
        send_seq();
        wait_idle(1500, t_idle);
        check_eq("t3_peak_level", 32'(peak), 32'd4);
        check_eq("t3_ready_low_when_full", 32'(full_bad), 32'd0);
        check_eq("t3_frames_seen", 32'(fall_q.size()), 32'd6);
        for (int i = 1; i < fall_q.size(); i++)
            check_eq("t3_frame_spacing", 32'(fall_q[i] - fall_q[i-1]), 32'(BIT_CYC * 10));
        repeat (20) @(negedge clk);

        // Reset during data bit 3, with a second word still queued
        set_cfg(0);
        wq.delete(); wq.push_back(9'h00F); wq.push_back(9'h033);
        send_seq();
        n = 0;
        while (tx_mon === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("t5_start_seen", 32'(n < 100), 32'd1);
        repeat (BIT_CYC * 4 + BIT_CYC / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_tx_after_rst", 32'(tx_a), 32'd1);
        check_eq("t5_busy_after_rst", 32'(busy_a), 32'd0);
        check_eq("t5_level_after_rst", 32'(level_a), 32'd0);
        check_eq("t5_ready_after_rst", 32'(ready_a), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (200) @(negedge clk);
        check_eq("t5_no_stale_frame", 32'(fall_q.size()), 32'd1);
        check_eq("t5_busy_quiet", 32'(busy_a), 32'd0);
        set_cfg(0);
        wq.delete(); wq.push_back(9'h081);
        send_seq();
        wait_idle(400, t_idle);
        check_eq("t5_clean_frames", 32'(fall_q.size()), 32'd1);
        repeat (20) @(negedge clk);

        // 7-bit, 2 stop bits, odd parity when enabled
        set_cfg(1);
        wq.delete(); wq.push_back(9'h003);
        send_seq();
        wait_idle(400, t_idle);
        f0 = (fall_q.size() > 0) ? fall_q[0] : 0;
        check_eq("t4_busy_fall_offset", 32'(t_idle - f0),
                 32'(BIT_CYC * (PAR_ON_B ? 11 : 10) - 1));
        repeat (20) @(negedge clk);

        // 9-bit characters
        set_cfg(2);
        wq.delete(); wq.push_back(9'h1AB);
        send_seq();
        wait_idle(400, t_idle);
        f0 = (fall_q.size() > 0) ? fall_q[0] : 0;
        check_eq("t6_busy_fall_offset", 32'(t_idle - f0), 32'(BIT_CYC * 11 - 1));
        repeat (20) @(negedge clk);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the team's fixed 8N1 RS-232 transmitter.
- Serialises words of configurable width, with 1 or 2 stop bits and optional parity, at a compile-time baud rate.
- Uses a fractional-accumulator baud generator.
- A small input FIFO with a valid/ready handshake sits between the system-side producer and the tx pin, so back-to-back characters go out with no idle gap.

Parameters:
- CLK_FREQ, 25000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- ACC_WIDTH, 16: baud accumulator fraction width; the accumulator register is ACC_WIDTH+1 bits.
- DATA_BITS, 8: payload bits per character; legal range 5..9.
- STOP_BITS, 1: stop bits per character; legal values 1 or 2.
- PARITY, 0: 0 none, 1 even, 2 odd. Honoured only when UART_TX_PARITY_EN is defined.
- FIFO_DEPTH, 4: input FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DATA_BITS  character to send, LSB transmitted first.
- s_valid  in  1  producer offers s_data.
- s_ready  out  1  FIFO can accept; equals !full.
- tx  out  1  serial line, idle high, registered.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

Behaviour:
- Interface: one clock, clk; rst is synchronous and active-high.
- Reset values: tx=1, busy=0, s_ready=1, fifo_level=0, FIFO pointers=0, accumulator=0, FSM=IDLE.
- Baud increment: INC = ((BAUD<<(ACC_WIDTH-4)) + (CLK_FREQ>>5)) / (CLK_FREQ>>4), evaluated at elaboration.
  - While FSM != IDLE: acc <= acc[ACC_WIDTH-1:0] + INC.
  - In IDLE: acc is held at 0, so every frame's first bit has a deterministic length.
  - tick = acc[ACC_WIDTH].
- FIFO write: occurs when s_valid & s_ready. A write while full is impossible because s_ready=0; s_data is ignored.
- FIFO read (pop): occurs in IDLE when not empty. The popped word is latched into a shift register, and the FSM moves to START in the same cycle.
- Simultaneous write and pop: both happen; fifo_level is unchanged. A write into an empty FIFO is poppable the next cycle (one-cycle latency from accept to pop).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START: on pop.
  - START -> DATA: on tick.
  - DATA: the bit counter counts DATA_BITS ticks, shifting LSB-first. After the last data bit, go to PARITY if enabled, else STOP.
  - PARITY -> STOP: on tick.
  - STOP: counts STOP_BITS ticks, then goes to IDLE. If the FIFO is non-empty at that final tick, pop directly and enter START in the same cycle (no idle bit between frames).
- tx register: START drives 0; DATA drives the shift-register LSB; PARITY drives the parity bit; STOP and IDLE drive 1. tx lags the state by one clk cycle, which makes it glitch-free.
- Bit length: each bit lasts exactly the clk cycles between consecutive ticks.
- busy = (FSM != IDLE) | (fifo_level != 0).
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap naturally. Full and empty are derived from fifo_level.
- Reset mid-frame: the frame is aborted, tx returns high on the next cycle, and the FIFO contents are discarded.
- Elaboration checks: DATA_BITS outside 5..9, STOP_BITS not in {1,2}, or FIFO_DEPTH not a power of two fails elaboration via $error.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: when PARITY is 1 or 2, a PARITY state is inserted after DATA.
  - Parity bit = ^data for even, ~^data for odd, computed on the latched word at pop.
  - Frame length = 1 + DATA_BITS + 1 + STOP_BITS bits.
- Not defined: the PARITY state and its logic are absent and the PARITY parameter is ignored. Frame length = 1 + DATA_BITS + STOP_BITS bits.

Decomposition:
- Package uart_pkg:
  - typedef enum tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - function baud_inc(clk_freq, baud, acc_width), shared with a future receiver.
- Sub-module uart_baud_gen: parameters CLK_FREQ, BAUD, ACC_WIDTH; ports clk, rst, en, tick. Holds acc at 0 while en=0.
- The FIFO stays inline.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD=100000, ACC_WIDTH=16, which gives INC=4096, i.e. a tick every 16 cycles.
1. Single 8N1 frame: write 0xA5 -> tx low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high; busy falls after the stop bit; total 160 cycles.
2. Back-to-back frames: write 0x00, 0xFF, 0x55 in consecutive cycles -> fifo_level peaks at 2; three frames with no high gap beyond the stop bit; 480 cycles total.
3. Full FIFO: hold s_valid with 6 words, FIFO_DEPTH=4, tx stalled -> s_ready=0 once fifo_level=4; words 5 and 6 are accepted only as pops free entries; no word is lost or duplicated.
4. Parity with UART_TX_PARITY_EN, PARITY=2, DATA_BITS=7, STOP_BITS=2: send 0x03 -> parity bit 1 (odd); frame of 11 bits = 176 cycles.
5. Reset mid-frame: assert rst during data bit 3 of 0x0F -> tx=1 the next cycle, busy=0, fifo_level=0; a following write of 0x81 produces a clean full frame.
6. DATA_BITS=9, STOP_BITS=1: send 0x1AB -> 9 data bits sent LSB first, MSB 1 last; frame of 11 bits.
